// File: rtl/pc_ras_sequencer_if.sv
// Control and status bundle between the fetch control logic and the PC/RAS
// sequencer. The master issues stall/branch/call/return requests; the slave
// (the sequencer) returns the current PC, PC+4 and the RAS status.
interface pc_ras_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int PTR_W = 2
);
  logic             stall;
  logic             branch;
  logic [WIDTH-1:0] branch_target;
  logic             call;
  logic [WIDTH-1:0] call_target;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [PTR_W:0]   ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, branch, branch_target, call, call_target, ret,
    input  pc, pc_plus4, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, branch, branch_target, call, call_target, ret,
    output pc, pc_plus4, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras_sequencer.sv
// Program-counter sequencer with a small circular return-address stack.
// Chooses the next PC from sequential, branch, call and return sources with
// fixed priority stall > ret > call > branch > sequential. Calls push PC+4,
// returns pop it back; a full stack silently overwrites its oldest entry and
// an empty-stack return falls through to PC+4. Both cases raise sticky flags.
module pc_ras_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 4,
  parameter int               PTR_W    = 2
) (
  input logic                clk,
  input logic                rst,
  pc_ras_sequencer_if.slave  bus
);

  // Clears the low two bits so every loaded PC is word-aligned.
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ras [DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_up;
  logic [PTR_W-1:0] top_down;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             underflow;
  logic [WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + FOUR;
  assign top_up   = top + PTR_ONE;
  assign top_down = top - PTR_ONE;

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.ras_count     = count;
  assign bus.ras_overflow  = overflow;
  assign bus.ras_underflow = underflow;

  // PC, stack and sticky flags; one action per cycle chosen by priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC & ALIGN_MASK;
      top       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else if (!bus.stall) begin
      if (bus.ret) begin
        if (count != '0) begin
          pc_q  <= ras[top] & ALIGN_MASK;
          top   <= top_down;
          count <= count - CNT_ONE;
        end else begin
          pc_q      <= pc_plus4;
          underflow <= 1'b1;
        end
      end else if (bus.call) begin
        ras[top_up] <= pc_plus4;
        top         <= top_up;
        pc_q        <= bus.call_target & ALIGN_MASK;
        if (count == CNT_FULL) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end else if (bus.branch) begin
        pc_q <= bus.branch_target & ALIGN_MASK;
      end else begin
        pc_q <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_pc_ras_sequencer.sv
// Directed bench for pc_ras_sequencer: sequential fetch, call/return pairs,
// stack overflow/underflow, stall, alignment, wrap-around and async reset.
module tb_pc_ras_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_ras_sequencer_if #(.WIDTH(32), .PTR_W(2)) bus ();

  pc_ras_sequencer #(
    .WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(4), .PTR_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value to its expected value and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of controls, clock it in, and settle 1 ns past the edge.
  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] bt,
                               input logic c, input logic [31:0] ct, input logic r);
    bus.stall         = s;
    bus.branch        = b;
    bus.branch_target = bt;
    bus.call          = c;
    bus.call_target   = ct;
    bus.ret           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic checkState(input string tag, input logic [31:0] pc,
                            input logic [31:0] cnt);
    checkOutput({tag, ".pc"}, bus.pc, pc);
    checkOutput({tag, ".pc4"}, bus.pc_plus4, pc + 32'd4);
    checkOutput({tag, ".cnt"}, 32'(bus.ras_count), cnt);
  endtask

  logic [31:0] pops [4];

  initial begin
    checks = 0;
    errors = 0;
    pops[0] = 32'h504; pops[1] = 32'h404; pops[2] = 32'h304; pops[3] = 32'h204;
    bus.stall = 0; bus.branch = 0; bus.branch_target = 0;
    bus.call = 0; bus.call_target = 0; bus.ret = 0;
    rst = 1'b1;
    #2;
    checkState("reset", 32'h0, 0);
    checkOutput("reset.ovf", 32'(bus.ras_overflow), 0);
    checkOutput("reset.unf", 32'(bus.ras_underflow), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 4; i++) begin
      idle();
      checkState($sformatf("seq%0d", i), 32'(i * 4), 0);
    end

    // Call / return pair from 0x10
    applyStimulus(0, 0, 0, 1, 32'h100, 0);
    checkState("call1", 32'h100, 1);
    idle();
    checkState("call1.i1", 32'h104, 1);
    idle();
    checkState("call1.i2", 32'h108, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkState("ret1", 32'h14, 0);

    // Five calls from 0x20 overflow the 4-entry stack
    applyStimulus(0, 1, 32'h20, 0, 0, 0);
    checkState("br20", 32'h20, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h200 + 32'(i) * 32'h100, 0);
      checkState($sformatf("callx%0d", i), 32'h200 + 32'(i) * 32'h100, (i < 4) ? i + 1 : 4);
      checkOutput($sformatf("callx%0d.ovf", i), 32'(bus.ras_overflow), (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkState($sformatf("pop%0d", i), pops[i], 32'(3 - i));
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkState("pop_empty", 32'h208, 0);
    checkOutput("pop_empty.unf", 32'(bus.ras_underflow), 1);

    // Stall holds everything, including a pending branch and call
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 32'h80, (i == 2), 32'h900, 0);
      checkState($sformatf("stall%0d", i), 32'h208, 0);
    end
    applyStimulus(0, 1, 32'h80, 0, 0, 0);
    checkState("unstall_br", 32'h80, 0);
    applyStimulus(0, 1, 32'h83, 0, 0, 0);
    checkState("br_align", 32'h80, 0);
    checkOutput("sticky.unf", 32'(bus.ras_underflow), 1);
    checkOutput("sticky.ovf", 32'(bus.ras_overflow), 1);

    // Wrap-around at the top of the address space
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    checkOutput("wrap.pc", bus.pc, 32'hFFFF_FFFC);
    checkOutput("wrap.pc4", bus.pc_plus4, 32'h0000_0000);
    idle();
    checkState("wrap.next", 32'h0, 0);

    // Ret beats Call when both asserted
    applyStimulus(0, 1, 32'h40, 0, 0, 0);
    checkState("br40", 32'h40, 0);
    applyStimulus(0, 0, 0, 1, 32'h303, 0);
    checkState("call_align", 32'h300, 1);
    applyStimulus(0, 0, 0, 1, 32'h500, 1);
    checkState("retcall", 32'h44, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkState("no_push", 32'h48, 0);

    // Asynchronous reset between edges, while stalled
    bus.stall = 1'b1;
    rst = 1'b1;
    #2;
    checkState("midrst", 32'h0, 0);
    checkOutput("midrst.ovf", 32'(bus.ras_overflow), 0);
    checkOutput("midrst.unf", 32'(bus.ras_underflow), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    checkState("post_rst", 32'h4, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkState("post_rst_pop", 32'h8, 0);
    checkOutput("post_rst_pop.unf", 32'(bus.ras_underflow), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
